// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes, burst-type code, slave FSM
// states and a constant-foldable log2 helper.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Smallest r with 2**r >= v
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_slv_mem_if.sv
// Wishbone bus bundle between an interconnect port (master) and the slave memory.
interface wb_slv_mem_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   din;
    logic [DW-1:0]   dout;
    logic            cyc;
    logic            stb;
    logic [DW/8-1:0] sel;
    logic            we;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output adr, din, cyc, stb, sel, we, cti, bte,
        input  dout, ack, err, rty
    );

    modport slave (
        input  adr, din, cyc, stb, sel, we, cti, bte,
        output dout, ack, err, rty
    );
endinterface

// File: rtl/wb_slv_mem_ram.sv
// Single-port byte-enable RAM. Read data is registered, carries only the
// enabled byte lanes, and is zero in any cycle following a non-read edge.
module wb_slv_mem_ram #(
    parameter int unsigned DW     = 32,
    parameter int unsigned MEM_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DW/8-1:0]   be,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 2 ** MEM_AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Masked read word for the next cycle
    always_comb begin
        rdata_d = '0;
        if (re) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (be[i]) begin
                    rdata_d[i*8 +: 8] = mem[addr][i*8 +: 8];
                end
            end
        end
    end

    // Read data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane write; array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_slv_mem.sv
// Wishbone classic / registered-feedback slave memory with programmable wait
// states, address-range error and retry injection.
// Build option: define WB_SLV_MEM_BURST_EN to enable linear incrementing
// bursts (cti=010, bte=00); otherwise every beat is a single classic access.
module wb_slv_mem
    import wb_pkg::*;
#(
    parameter int unsigned    DW     = 32,
    parameter int unsigned    AW     = 32,
    parameter int unsigned    MEM_AW = 13,
    parameter logic [AW-1:0]  BASE   = '0,
    parameter int unsigned    WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_slv_mem_if.slave       bus,
    input  logic [WAIT_W-1:0] cfg_wait,
    input  logic              rty_inj
);
    localparam int unsigned LSB = clog2(DW / 8);
    localparam int unsigned HI  = MEM_AW + LSB;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rty_q, rty_d;

    logic                req_c;
    logic                in_range_c;
    logic [MEM_AW-1:0]   idx_c;
    logic                ram_we_c;
    logic                ram_re_c;
    logic [MEM_AW-1:0]   ram_addr_c;
    logic [DW-1:0]       rdata;

    assign req_c      = bus.cyc & bus.stb;
    assign in_range_c = (bus.adr >> HI) == BASE;
    assign idx_c      = bus.adr[HI-1:LSB];

`ifndef WB_SLV_MEM_BURST_EN
    // Burst qualifiers have no effect in the classic-only build
    logic unused_burst_c;
    assign unused_burst_c = ^{bus.cti, bus.bte};
`endif

    // Next-state, response and RAM-control decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = addr_q;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    we_d   = bus.we;
                    addr_d = idx_c;
                    if (!in_range_c) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (rty_inj) begin
                        rty_d   = 1'b1;
                        state_d = RESP;
                    end else if (cfg_wait == '0) begin
                        ack_d      = 1'b1;
                        ram_re_c   = !bus.we;
                        ram_addr_c = idx_c;
                        state_d    = RESP;
                    end else begin
                        cnt_d   = cfg_wait;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!req_c) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    ack_d    = 1'b1;
                    ram_re_c = !we_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end

            RESP: begin
                ram_we_c = ack_q & we_q;
                state_d  = IDLE;
`ifdef WB_SLV_MEM_BURST_EN
                // Back-to-back beat while the master keeps signalling INCR
                if (ack_q && req_c && (bus.cti == CTI_INCR)) begin
                    state_d = RESP;
                    addr_d  = addr_q + MEM_AW'(1);
                    if ((&addr_q) || (bus.bte != BTE_LINEAR)) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d    = 1'b1;
                        ram_re_c = !we_q;
                        if (!we_q) begin
                            ram_addr_c = addr_d;
                        end
                    end
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
        end
    end

    wb_slv_mem_ram #(
        .DW     (DW),
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .addr  (ram_addr_c),
        .be    (bus.sel),
        .wdata (bus.din),
        .rdata (rdata)
    );

    assign bus.dout = rdata;
    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.rty  = rty_q;

endmodule

// File: tb/tb_wb_slv_mem.sv
// Directed bench for wb_slv_mem: vector table of single accesses plus
// hand sequences for cfg_wait sampling, abort, reset mid-access and bursts.
module tb_wb_slv_mem;
    import wb_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] cfg_wait;
    logic       rty_inj;

    int n_pass  = 0;
    int n_total = 0;

    wb_slv_mem_if #(.AW(32), .DW(32)) bus ();

    wb_slv_mem dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cfg_wait (cfg_wait),
        .rty_inj  (rty_inj)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] din;
        logic [3:0]  sel;
        int          wt;
        bit          ri;
        logic [2:0]  exp_resp;   // {ack, err, rty}
        int          exp_lat;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_bus();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0;   bus.din = '0;   bus.sel = '0;
        bus.cti = CTI_CLASSIC; bus.bte = BTE_LINEAR;
    endtask

    // One classic access; holds the request through the response cycle
    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int wt, input int wt_after,
                             input bit ri, output logic [2:0] resp, output int lat,
                             output logic [31:0] rd);
        cfg_wait = 4'(wt);
        rty_inj  = ri;
        bus.adr = a; bus.din = d; bus.sel = s; bus.we = w;
        bus.cti = CTI_CLASSIC; bus.bte = BTE_LINEAR;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        resp = 3'b000; lat = 0; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) cfg_wait = 4'(wt_after);
            if (bus.ack | bus.err | bus.rty) begin
                resp = {bus.ack, bus.err, bus.rty};
                lat  = k;
                rd   = bus.dout;
                break;
            end
        end
        @(posedge clk); #1;
        idle_bus();
        rty_inj = 1'b0;
    endtask

    logic [2:0]  r;
    int          lat;
    logic [31:0] rd;
    int          beat;
    bit          pend;
    int          exp_cyc[4];

    initial begin
        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 1'b0, 3'b100, 1, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 0, 1'b0, 3'b100, 1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 0, 1'b0, 3'b100, 1, 32'h0};
        vecs[3]  = '{1'b1, 32'h20,   32'h0000AB00, 4'h2, 3, 1'b0, 3'b100, 4, 32'h0};
        vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 3, 1'b0, 3'b100, 4, 32'h1122AB44};
        vecs[5]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 0, 1'b0, 3'b100, 1, 32'h0};
        vecs[6]  = '{1'b1, 32'h8000, 32'h55555555, 4'hF, 3, 1'b0, 3'b010, 1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,    32'h0,        4'hF, 0, 1'b0, 3'b100, 1, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 32'h30,   32'hA5A5A5A5, 4'hF, 0, 1'b0, 3'b100, 1, 32'h0};
        vecs[9]  = '{1'b1, 32'h30,   32'h12345678, 4'hF, 2, 1'b1, 3'b001, 1, 32'h0};
        vecs[10] = '{1'b0, 32'h30,   32'h0,        4'hF, 0, 1'b0, 3'b100, 1, 32'hA5A5A5A5};
        vecs[11] = '{1'b1, 32'h30,   32'h12345678, 4'hF, 2, 1'b0, 3'b100, 3, 32'h0};
        vecs[12] = '{1'b0, 32'h30,   32'h0,        4'hF, 0, 1'b0, 3'b100, 1, 32'h12345678};
        vecs[13] = '{1'b0, 32'h10,   32'h0,        4'h5, 1, 1'b0, 3'b100, 2, 32'h00AD00EF};
        vecs[14] = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 0, 1'b0, 3'b100, 1, 32'h0};
        vecs[15] = '{1'b0, 32'h13,   32'h0,        4'hF, 0, 1'b0, 3'b100, 1, 32'hDEADBEEF};
        vecs[16] = '{1'b0, 32'h8004, 32'h0,        4'hF, 0, 1'b1, 3'b010, 1, 32'h0};
        vecs[17] = '{1'b1, 32'h7FFC, 32'h77777777, 4'hF, 1, 1'b0, 3'b100, 2, 32'h0};
        vecs[18] = '{1'b0, 32'h7FFC, 32'h0,        4'hF, 0, 1'b0, 3'b100, 1, 32'h77777777};
        vecs[19] = '{1'b1, 32'h50,   32'h0BADCAFE, 4'hF, 0, 1'b0, 3'b100, 1, 32'h0};
        vecs[20] = '{1'b1, 32'h60,   32'h60606060, 4'hF, 0, 1'b0, 3'b100, 1, 32'h0};

        // Reset values
        rst = 1'b1; cfg_wait = '0; rty_inj = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", 32'({bus.ack, bus.err, bus.rty}), 32'h0);
        check("reset_dout", bus.dout, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        foreach (vecs[i]) begin
            do_access(vecs[i].we, vecs[i].adr, vecs[i].din, vecs[i].sel, vecs[i].wt,
                      vecs[i].wt, vecs[i].ri, r, lat, rd);
            check($sformatf("v%0d_resp", i), 32'(r), 32'(vecs[i].exp_resp));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_dout", i), rd, vecs[i].exp_dout);
            check($sformatf("v%0d_after", i), 32'({bus.ack, bus.err, bus.rty}), 32'h0);
            check($sformatf("v%0d_after_dout", i), bus.dout, 32'h0);
        end

        // cfg_wait changed after acceptance has no effect on the access in flight
        do_access(1'b0, 32'h20, 32'h0, 4'hF, 3, 0, 1'b0, r, lat, rd);
        check("wait_sampled_lat", 32'(lat), 32'd4);
        check("wait_sampled_dout", rd, 32'h1122AB44);

        // Abort a write in WAIT after two wait cycles
        cfg_wait = 4'd5;
        bus.adr = 32'h50; bus.din = 32'hFFFFFFFF; bus.sel = 4'hF; bus.we = 1'b1;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_wait", 32'({bus.ack, bus.err, bus.rty}), 32'h0);
        end
        bus.cyc = 1'b0; bus.stb = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'({bus.ack, bus.err, bus.rty}), 32'h0);
        end
        idle_bus();
        do_access(1'b0, 32'h50, 32'h0, 4'hF, 0, 0, 1'b0, r, lat, rd);
        check("abort_next_resp", 32'(r), 32'h4);
        check("abort_next_lat", 32'(lat), 32'd1);
        check("abort_word_kept", rd, 32'h0BADCAFE);

        // Reset in the middle of a waiting write
        cfg_wait = 4'd4;
        bus.adr = 32'h60; bus.din = 32'h0; bus.sel = 4'hF; bus.we = 1'b1;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_resp", 32'({bus.ack, bus.err, bus.rty}), 32'h0);
        idle_bus();
        @(posedge clk); #1;
        rst = 1'b0;
        do_access(1'b0, 32'h60, 32'h0, 4'hF, 0, 0, 1'b0, r, lat, rd);
        check("midreset_lat", 32'(lat), 32'd1);
        check("midreset_word", rd, 32'h60606060);

        // 4-beat incrementing read from 0x40 with two wait states
        for (int i = 0; i < 4; i++) begin
            do_access(1'b1, 32'h40 + 32'(i * 4), 32'hB0000000 + 32'(i), 4'hF, 0, 0, 1'b0, r, lat, rd);
            check("burst_preload", 32'(r), 32'h4);
        end
`ifdef WB_SLV_MEM_BURST_EN
        exp_cyc = '{3, 4, 5, 6};
`else
        exp_cyc = '{3, 7, 11, 15};
`endif
        cfg_wait = 4'd2;
        bus.adr = 32'h40; bus.we = 1'b0; bus.sel = 4'hF; bus.din = '0;
        bus.cti = CTI_INCR; bus.bte = BTE_LINEAR;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        beat = 0; pend = 1'b0;
        for (int k = 1; k <= 40 && beat < 4; k++) begin
            @(posedge clk); #1;
            if (pend) begin
                pend = 1'b0;
                bus.adr = bus.adr + 32'd4;
                bus.cti = (beat == 3) ? CTI_EOB : CTI_INCR;
            end
            if (bus.ack | bus.err | bus.rty) begin
                check("burst_resp", 32'({bus.ack, bus.err, bus.rty}), 32'h4);
                check("burst_cycle", 32'(k), 32'(exp_cyc[beat]));
                check("burst_dout", bus.dout, 32'hB0000000 + 32'(beat));
                beat++;
                pend = 1'b1;
            end
        end
        check("burst_beats", 32'(beat), 32'd4);
        @(posedge clk); #1;
        idle_bus();
        check("burst_after", 32'({bus.ack, bus.err, bus.rty}), 32'h0);
        check("burst_after_dout", bus.dout, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
